// File: rtl/sync_lock_ctrl.sv
// Frame-sync acquisition/tracking controller.
// Sequences the windowed SOP-peak statistics counter through
// IDLE/SEARCH/VERIFY/LOCK. It declares lock after enough consecutive hit
// windows and drops it after enough consecutive miss windows.
module sync_lock_ctrl #(
  parameter int unsigned pTM_W  = 24,
  parameter int unsigned pST_W  = 8,
  parameter int unsigned pCNT_W = 4
) (
  input  logic              iclk,
  input  logic              ireset,
  input  logic              iena,
  input  logic [pST_W-1:0]  istat,
  input  logic              ival,
  input  logic [pST_W-1:0]  ilock_thr,
  input  logic [pST_W-1:0]  iloss_thr,
  input  logic [pCNT_W-1:0] inum_confirm,
  input  logic [pCNT_W-1:0] inum_miss,
  input  logic [pTM_W-1:0]  iframe_search,
  input  logic [pTM_W-1:0]  iframe_track,
  output logic [pTM_W-1:0]  oframe_time,
  output logic              ostat_ena,
  output logic [1:0]        ostate,
  output logic              olock,
  output logic              olock_pls,
  output logic              oloss_pls,
  output logic [pST_W-1:0]  olock_num
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSearch = 2'd1,
    StVerify = 2'd2,
    StLock   = 2'd3
  } state_e;

  localparam logic [pCNT_W-1:0] CntOne = {{(pCNT_W-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [pCNT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic [pCNT_W-1:0]  miss_cnt_q, miss_cnt_d;
  logic [pTM_W-1:0]   frame_time_q, frame_time_d;
  logic               stat_ena_q, stat_ena_d;
  logic               lock_q, lock_d;
  logic               lock_pls_q, lock_pls_d;
  logic               loss_pls_q, loss_pls_d;
  logic [pST_W-1:0]   lock_num_q, lock_num_d;

  logic [pCNT_W-1:0]  confirm_eff;
  logic [pCNT_W-1:0]  miss_eff;
  logic [pCNT_W:0]    hit_inc;
  logic [pCNT_W:0]    miss_inc;
  logic               is_hit;
  logic               is_miss;
  logic               enter_lock;

  // A zero threshold behaves as one so a single window is always enough.
  assign confirm_eff = (inum_confirm == '0) ? CntOne : inum_confirm;
  assign miss_eff    = (inum_miss == '0) ? CntOne : inum_miss;
  assign hit_inc     = {1'b0, hit_cnt_q} + {1'b0, CntOne};
  assign miss_inc    = {1'b0, miss_cnt_q} + {1'b0, CntOne};
  assign is_hit      = (istat >= ilock_thr);
  assign is_miss     = (istat < iloss_thr);

  // Next-state, counter and registered-output decisions.
  always_comb begin
    state_d      = state_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    frame_time_d = frame_time_q;
    lock_pls_d   = 1'b0;
    loss_pls_d   = 1'b0;
    lock_num_d   = lock_num_q;
    enter_lock   = 1'b0;

    if (!iena) begin
      // Disable wins over any strobe; frame time and lock count are held.
      state_d    = StIdle;
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d      = StSearch;
          frame_time_d = iframe_search;
        end
        StSearch: begin
          if (ival && is_hit) begin
            if (confirm_eff == CntOne) begin
              enter_lock = 1'b1;
            end else begin
              state_d   = StVerify;
              hit_cnt_d = CntOne;
            end
          end
        end
        StVerify: begin
          if (ival) begin
            if (is_hit) begin
              // >= keeps the count bounded if the threshold is lowered mid-verify.
              if (hit_inc >= {1'b0, confirm_eff}) begin
                enter_lock = 1'b1;
              end else begin
                hit_cnt_d = hit_inc[pCNT_W-1:0];
              end
            end else begin
              state_d   = StSearch;
              hit_cnt_d = '0;
            end
          end
        end
        StLock: begin
          if (ival) begin
            if (is_miss) begin
              if (miss_inc >= {1'b0, miss_eff}) begin
                state_d      = StSearch;
                loss_pls_d   = 1'b1;
                frame_time_d = iframe_search;
                miss_cnt_d   = '0;
              end else begin
                miss_cnt_d = miss_inc[pCNT_W-1:0];
              end
            end else begin
              miss_cnt_d = '0;
            end
          end
        end
        default: state_d = StIdle;
      endcase

      if (enter_lock) begin
        state_d      = StLock;
        lock_pls_d   = 1'b1;
        lock_num_d   = (&lock_num_q) ? lock_num_q : lock_num_q + {{(pST_W-1){1'b0}}, 1'b1};
        frame_time_d = iframe_track;
        hit_cnt_d    = '0;
        miss_cnt_d   = '0;
      end
    end

    stat_ena_d = (state_d != StIdle);
    lock_d     = (state_d == StLock);
  end

  // State and output registers.
  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      state_q      <= StIdle;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      frame_time_q <= '0;
      stat_ena_q   <= 1'b0;
      lock_q       <= 1'b0;
      lock_pls_q   <= 1'b0;
      loss_pls_q   <= 1'b0;
      lock_num_q   <= '0;
    end else begin
      state_q      <= state_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      frame_time_q <= frame_time_d;
      stat_ena_q   <= stat_ena_d;
      lock_q       <= lock_d;
      lock_pls_q   <= lock_pls_d;
      loss_pls_q   <= loss_pls_d;
      lock_num_q   <= lock_num_d;
    end
  end

  assign oframe_time = frame_time_q;
  assign ostat_ena   = stat_ena_q;
  assign ostate      = state_q;
  assign olock       = lock_q;
  assign olock_pls   = lock_pls_q;
  assign oloss_pls   = loss_pls_q;
  assign olock_num   = lock_num_q;

endmodule

// File: tb/tb_sync_lock_ctrl.sv
// Bench for sync_lock_ctrl: directed vector table, hand-written corner
// sequences, then random stimulus checked against a behavioural model.
module tb_sync_lock_ctrl;

  logic        iclk;
  logic        ireset;
  logic        iena;
  logic [7:0]  istat;
  logic        ival;
  logic [7:0]  ilock_thr;
  logic [7:0]  iloss_thr;
  logic [3:0]  inum_confirm;
  logic [3:0]  inum_miss;
  logic [23:0] iframe_search;
  logic [23:0] iframe_track;
  logic [23:0] oframe_time;
  logic        ostat_ena;
  logic [1:0]  ostate;
  logic        olock;
  logic        olock_pls;
  logic        oloss_pls;
  logic [7:0]  olock_num;

  int checks = 0;
  int failures = 0;

  sync_lock_ctrl #(
    .pTM_W  (24),
    .pST_W  (8),
    .pCNT_W (4)
  ) u_dut (
    .iclk          (iclk),
    .ireset        (ireset),
    .iena          (iena),
    .istat         (istat),
    .ival          (ival),
    .ilock_thr     (ilock_thr),
    .iloss_thr     (iloss_thr),
    .inum_confirm  (inum_confirm),
    .inum_miss     (inum_miss),
    .iframe_search (iframe_search),
    .iframe_track  (iframe_track),
    .oframe_time   (oframe_time),
    .ostat_ena     (ostat_ena),
    .ostate        (ostate),
    .olock         (olock),
    .olock_pls     (olock_pls),
    .oloss_pls     (oloss_pls),
    .olock_num     (olock_num)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  typedef struct {
    logic        ena;
    logic        val;
    logic [7:0]  stat;
    logic [1:0]  st;
    logic        lp;
    logic        lsp;
    logic [23:0] ft;
    logic [7:0]  num;
  } vec_t;

  vec_t vecs [17];

  // Behavioural model: phase 0..3, streak lengths as plain integers.
  int          m_phase;
  int          m_hits;
  int          m_misses;
  int          m_lock_count;
  logic [23:0] m_ft;
  logic        m_lp;
  logic        m_lsp;

  task automatic check(input string name, input logic [1:0] st, input logic lp,
                       input logic lsp, input logic [23:0] ft, input logic [7:0] num);
    logic [37:0] exp_v;
    logic [37:0] act_v;
    exp_v = {st, (st != 2'd0), (st == 2'd3), lp, lsp, ft, num};
    act_v = {ostate, ostat_ena, olock, olock_pls, oloss_pls, oframe_time, olock_num};
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL %s: got st=%0d ena=%0b lock=%0b lp=%0b lsp=%0b ft=%0d num=%0d, expected st=%0d lp=%0b lsp=%0b ft=%0d num=%0d",
               name, ostate, ostat_ena, olock, olock_pls, oloss_pls, oframe_time, olock_num,
               st, lp, lsp, ft, num);
    end
  endtask

  task automatic step();
    @(posedge iclk);
    #1;
  endtask

  task automatic model_reset();
    m_phase      = 0;
    m_hits       = 0;
    m_misses     = 0;
    m_lock_count = 0;
    m_ft         = '0;
    m_lp         = 1'b0;
    m_lsp        = 1'b0;
  endtask

  // Advances the model by one clock using the inputs present at that edge.
  task automatic model_clock();
    int need_hits;
    int need_miss;
    logic got_lock;
    need_hits = (inum_confirm == 0) ? 1 : int'(inum_confirm);
    need_miss = (inum_miss == 0) ? 1 : int'(inum_miss);
    got_lock  = 1'b0;
    m_lp      = 1'b0;
    m_lsp     = 1'b0;
    if (!iena) begin
      m_phase  = 0;
      m_hits   = 0;
      m_misses = 0;
    end else if (m_phase == 0) begin
      m_phase = 1;
      m_ft    = iframe_search;
    end else if (ival && m_phase != 3) begin
      // Searching/verifying: a streak of good windows long enough locks.
      if (int'(istat) >= int'(ilock_thr)) begin
        m_hits = m_hits + 1;
        if (m_hits >= need_hits) got_lock = 1'b1;
        else m_phase = 2;
      end else begin
        m_hits  = 0;
        m_phase = 1;
      end
    end else if (ival) begin
      if (int'(istat) < int'(iloss_thr)) begin
        m_misses = m_misses + 1;
        if (m_misses >= need_miss) begin
          m_phase  = 1;
          m_lsp    = 1'b1;
          m_ft     = iframe_search;
          m_misses = 0;
        end
      end else begin
        m_misses = 0;
      end
    end
    if (got_lock) begin
      m_phase  = 3;
      m_lp     = 1'b1;
      m_ft     = iframe_track;
      m_hits   = 0;
      m_misses = 0;
      if (m_lock_count < 255) m_lock_count = m_lock_count + 1;
    end
  endtask

  initial begin
    // ena, val, stat -> state, lock_pls, loss_pls, frame_time, lock_num
    vecs[0]  = '{1'b1, 1'b0, 8'd0, 2'd1, 1'b0, 1'b0, 24'd1000, 8'd0};
    vecs[1]  = '{1'b1, 1'b1, 8'd7, 2'd2, 1'b0, 1'b0, 24'd1000, 8'd0};
    vecs[2]  = '{1'b1, 1'b0, 8'd0, 2'd2, 1'b0, 1'b0, 24'd1000, 8'd0};
    vecs[3]  = '{1'b1, 1'b1, 8'd6, 2'd2, 1'b0, 1'b0, 24'd1000, 8'd0};
    vecs[4]  = '{1'b1, 1'b1, 8'd9, 2'd3, 1'b1, 1'b0, 24'd2000, 8'd1};
    vecs[5]  = '{1'b1, 1'b0, 8'd0, 2'd3, 1'b0, 1'b0, 24'd2000, 8'd1};
    vecs[6]  = '{1'b1, 1'b1, 8'd1, 2'd3, 1'b0, 1'b0, 24'd2000, 8'd1};
    vecs[7]  = '{1'b1, 1'b1, 8'd4, 2'd3, 1'b0, 1'b0, 24'd2000, 8'd1};
    vecs[8]  = '{1'b1, 1'b1, 8'd1, 2'd3, 1'b0, 1'b0, 24'd2000, 8'd1};
    vecs[9]  = '{1'b1, 1'b1, 8'd0, 2'd1, 1'b0, 1'b1, 24'd1000, 8'd1};
    vecs[10] = '{1'b1, 1'b0, 8'd0, 2'd1, 1'b0, 1'b0, 24'd1000, 8'd1};
    vecs[11] = '{1'b1, 1'b1, 8'd7, 2'd2, 1'b0, 1'b0, 24'd1000, 8'd1};
    vecs[12] = '{1'b1, 1'b1, 8'd2, 2'd1, 1'b0, 1'b0, 24'd1000, 8'd1};
    vecs[13] = '{1'b1, 1'b1, 8'd7, 2'd2, 1'b0, 1'b0, 24'd1000, 8'd1};
    vecs[14] = '{1'b1, 1'b1, 8'd7, 2'd2, 1'b0, 1'b0, 24'd1000, 8'd1};
    vecs[15] = '{1'b1, 1'b1, 8'd7, 2'd3, 1'b1, 1'b0, 24'd2000, 8'd2};
    vecs[16] = '{1'b1, 1'b0, 8'd0, 2'd3, 1'b0, 1'b0, 24'd2000, 8'd2};

    ireset        = 1'b0;
    iena          = 1'b0;
    ival          = 1'b0;
    istat         = '0;
    ilock_thr     = 8'd5;
    iloss_thr     = 8'd3;
    inum_confirm  = 4'd3;
    inum_miss     = 4'd2;
    iframe_search = 24'd1000;
    iframe_track  = 24'd2000;
    repeat (2) step();
    check("reset", 2'd0, 1'b0, 1'b0, 24'd0, 8'd0);
    ireset = 1'b1;
    step();
    check("idle_hold", 2'd0, 1'b0, 1'b0, 24'd0, 8'd0);

    // Directed vector table.
    for (int i = 0; i < 17; i++) begin
      iena  = vecs[i].ena;
      ival  = vecs[i].val;
      istat = vecs[i].stat;
      step();
      check($sformatf("vec%0d", i), vecs[i].st, vecs[i].lp, vecs[i].lsp, vecs[i].ft,
            vecs[i].num);
    end

    // Zero thresholds: single miss drops, single hit locks.
    inum_confirm = 4'd0;
    inum_miss    = 4'd0;
    ival = 1'b1; istat = 8'd0;
    step();
    check("miss0_drop", 2'd1, 1'b0, 1'b1, 24'd1000, 8'd2);
    istat = 8'd9;
    step();
    check("confirm0_lock", 2'd3, 1'b1, 1'b0, 24'd2000, 8'd3);
    istat = 8'd1;
    step();
    check("miss0_drop2", 2'd1, 1'b0, 1'b1, 24'd1000, 8'd3);

    // Disable on the same cycle as a locking strobe.
    iena = 1'b0; istat = 8'd9;
    step();
    check("ena_over_lock", 2'd0, 1'b0, 1'b0, 24'd1000, 8'd3);
    iena = 1'b1; ival = 1'b0;
    step();
    check("reenable", 2'd1, 1'b0, 1'b0, 24'd1000, 8'd3);
    inum_confirm = 4'd3;
    ival = 1'b1; istat = 8'd7;
    step();
    check("verify_again", 2'd2, 1'b0, 1'b0, 24'd1000, 8'd3);

    // Asynchronous reset mid-VERIFY, away from any clock edge.
    ival = 1'b0;
    #2 ireset = 1'b0;
    #1 check("async_reset", 2'd0, 1'b0, 1'b0, 24'd0, 8'd0);
    #2 ireset = 1'b1;

    // Random phase against the model, starting from reset.
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      iena  = ($urandom_range(0, 99) >= 3);
      ival  = ($urandom_range(0, 99) < 35);
      istat = 8'($urandom_range(0, 12));
      if ($urandom_range(0, 49) == 0) begin
        ilock_thr     = 8'($urandom_range(0, 10));
        iloss_thr     = 8'($urandom_range(0, 10));
        inum_confirm  = 4'($urandom_range(0, 4));
        inum_miss     = 4'($urandom_range(0, 4));
        iframe_search = 24'($urandom_range(1, 100000));
        iframe_track  = 24'($urandom_range(1, 100000));
      end
      step();
      model_clock();
      check($sformatf("rand%0d", cyc), 2'(m_phase), m_lp, m_lsp, m_ft, 8'(m_lock_count));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
